pipeline_alu_fwd: RTL
=====================

// Module: pipeline_alu_fwd
// PURPOSE
//  Parametrised 3-stage pipelined register-register ALU: operand read, execute, writeback.
//  Each result goes to the register bank and, optionally, to a data memory.
//  Full operand forwarding removes read-after-write hazards without stalls; it is the
//  single-clock, resettable, data-width-generic successor of the two-phase ALU pipeline.
//  Sits between the instruction issue logic and the data memory.
// PARAMETERS
//  DW    16  data width of regbank, memory, ALU
//  RAW   4   register address width; regbank depth 2**RAW
//  MAW   8   memory address width; memory depth 2**MAW
// PORTS
//  clk        in   1    single clock, all state on rising edge
//  rst        in   1    synchronous reset, active-high
//  in_valid   in   1    instruction present this cycle
//  rs1        in   RAW  source register A
//  rs2        in   RAW  source register B
//  rd         in   RAW  destination register
//  func       in   4    operation code
//  addr       in   MAW  memory write address
//  wb_mem     in   1    1 = also write result to mem[addr]
//  zout       out  DW   writeback-stage result
//  zout_valid out  1    zout holds a retired instruction
//  err        out  1    retired instruction had an illegal func
//  mem_raddr  in   MAW  debug read address
//  mem_rdata  out  DW   mem[mem_raddr], combinational
// BEHAVIOUR
//  Stages and registers:
//  - S1 (edge t0): latch A, B, rd, func, addr, wb_mem, valid.
//  - S2 (edge t0+1): latch the ALU result.
//  - S3 (edge t0+2): write regbank[rd], write mem[addr] if wb_mem, update zout/zout_valid/err.
//  - Latency: sampled at t0 -> zout valid after t0+2. Throughput 1/cycle, never stalls.
//  - in_valid=0 inserts a bubble: valid bit 0, no regbank or mem write, zout_valid=0 when it retires.
//  Operand bypass for rs1 and rs2 at S1, highest priority first:
//  - (a) valid S2 instruction with rd==rs: its combinational ALU result.
//  - (b) valid S3 instruction with rd==rs: the latched S2 result.
//  - (c) regbank[rs].
//  - Instructions three or more ahead are already written.
//  - Invalid or err instructions are never bypass sources.
//  ALU ops (all results truncated to DW, wrap modulo 2**DW):
//  - 0 A+B, 1 A-B, 2 A*B (low DW bits), 3 A, 4 B, 5 A&B, 6 A|B, 7 A^B.
//  - 8 -A, 9 -B, 10 A>>1, 11 A<<1.
//  - 12 A>>B[3:0] logical, 13 A<<B[3:0].
//  Illegal func (14, 15):
//  - Result 0, err=1 at retire, no regbank or mem write, zout_valid=1.
//  Simultaneous rd collisions:
//  - Two in-flight instructions with the same rd: the youngest wins the bypass; regbank takes the retire order.
//  - An S3 write and an S1 read of the same register in one cycle are covered by bypass (b).
//  Reset (also mid-operation):
//  - All valid bits cleared; in-flight instructions are dropped with no write.
//  - zout=0, zout_valid=0, err=0.
//  - regbank[k]=k for all k.
//  - Memory is not reset.
// TESTING
//  T1: rst, then rs1=6 rs2=4 rd=10 func=0 addr=125 wb_mem=1 -> zout=10 at t0+2; mem[125]=10; regbank[10]=10.
//  T2: back-to-back rs1=6 rs2=4 rd=10 func=0, then rs1=10 rs2=8 rd=11 func=2 addr=126 -> 2nd zout=80 via bypass (a); mem[126]=80.
//  T3: distance-2 hazard: rd=10 (6+4), a bubble, then rs1=10 rs2=1 func=1 -> zout=9 via bypass (b).
//  T4: func=14, rd=3, addr=127 -> zout=0, err=1, regbank[3]=3, mem[127] unchanged.
//  T5: wrap: rs1=1 func=8 rd=2 -> 16'hFFFF; then rs1=2 rs2=1 func=0 -> 16'h0000; func=13 with A=1 B=15 -> 16'h8000.
//  T6: rst asserted one cycle after issuing rd=5 func=0 -> no zout_valid, regbank[5]=5.

Source files
------------

// File: rtl/pipeline_alu_fwd.sv
// -----------------------------------------------------------------------------
// pipeline_alu_fwd
//
// Purpose
//   Three-stage pipelined register-register ALU with full operand forwarding.
//   Stage S1 reads operands, S2 executes, S3 writes back. The S3 result goes
//   to the register bank, optionally to a small data memory, and to zout.
//   Forwarding removes every read-after-write hazard, so the pipe never
//   stalls. It accepts one instruction per cycle, and each result is
//   visible two edges after issue.
//
// Parameters
//   DW   data width of register bank, memory and ALU
//   RAW  register address width (register bank depth 2**RAW)
//   MAW  memory address width (memory depth 2**MAW)
//
// Ports
//   clk         single clock, all state updates on the rising edge
//   rst         synchronous reset, active-high
//   in_valid    an instruction is presented this cycle
//   rs1, rs2    source register addresses (operands A and B)
//   rd          destination register address
//   func        4-bit operation code
//   addr        memory write address for this instruction
//   wb_mem      1 = also write the result to mem[addr]
//   zout        result of the instruction retiring in S3
//   zout_valid  zout holds a retired instruction (0 for bubbles)
//   err         the retired instruction had an illegal func
//   mem_raddr   debug read address
//   mem_rdata   mem[mem_raddr], combinational
//
// Handshake
//   There is no back-pressure: when in_valid is high, the instruction is
//   consumed on the next rising edge. zout/zout_valid/err are qualified only
//   by zout_valid and are held for exactly one cycle per retired instruction.
// -----------------------------------------------------------------------------
module pipeline_alu_fwd #(
    parameter int DW  = 16,
    parameter int RAW = 4,
    parameter int MAW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [RAW-1:0] rs1,
    input  logic [RAW-1:0] rs2,
    input  logic [RAW-1:0] rd,
    input  logic [3:0]     func,
    input  logic [MAW-1:0] addr,
    input  logic           wb_mem,
    output logic [DW-1:0]  zout,
    output logic           zout_valid,
    output logic           err,
    input  logic [MAW-1:0] mem_raddr,
    output logic [DW-1:0]  mem_rdata
);

    localparam int RB_DEPTH  = 2 ** RAW;
    localparam int MEM_DEPTH = 2 ** MAW;

    // Operation codes
    localparam logic [3:0] FN_ADD   = 4'd0;
    localparam logic [3:0] FN_SUB   = 4'd1;
    localparam logic [3:0] FN_MUL   = 4'd2;
    localparam logic [3:0] FN_PASSA = 4'd3;
    localparam logic [3:0] FN_PASSB = 4'd4;
    localparam logic [3:0] FN_AND   = 4'd5;
    localparam logic [3:0] FN_OR    = 4'd6;
    localparam logic [3:0] FN_XOR   = 4'd7;
    localparam logic [3:0] FN_NEGA  = 4'd8;
    localparam logic [3:0] FN_NEGB  = 4'd9;
    localparam logic [3:0] FN_SHR1  = 4'd10;
    localparam logic [3:0] FN_SHL1  = 4'd11;
    localparam logic [3:0] FN_SHRB  = 4'd12;
    localparam logic [3:0] FN_SHLB  = 4'd13;

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    logic [DW-1:0] r_regbank [RB_DEPTH];
    logic [DW-1:0] r_mem     [MEM_DEPTH];

    // S1 registers: operands and control of the instruction now executing.
    logic           r_s1_valid;
    logic [DW-1:0]  r_s1_a;
    logic [DW-1:0]  r_s1_b;
    logic [RAW-1:0] r_s1_rd;
    logic [3:0]     r_s1_func;
    logic [MAW-1:0] r_s1_addr;
    logic           r_s1_wb_mem;

    // S2 registers: latched ALU result of the instruction now retiring.
    logic           r_s2_valid;
    logic           r_s2_err;
    logic [DW-1:0]  r_s2_result;
    logic [RAW-1:0] r_s2_rd;
    logic [MAW-1:0] r_s2_addr;
    logic           r_s2_wb_mem;

    // S3 output registers.
    logic [DW-1:0]  r_zout;
    logic           r_zout_valid;
    logic           r_err;

    // Combinational signals
    logic [DW-1:0]  w_alu_result;
    logic           w_alu_illegal;
    logic [DW-1:0]  w_op_a;
    logic [DW-1:0]  w_op_b;
    logic           w_fwd_exec_ok;
    logic           w_fwd_retire_ok;
    logic           w_retire_write;

    // -------------------------------------------------------------------------
    // Execute: ALU on the S1 operand registers
    // -------------------------------------------------------------------------
    always_comb begin
        w_alu_result  = '0;
        w_alu_illegal = 1'b0;
        unique case (r_s1_func)
            FN_ADD:   w_alu_result = r_s1_a + r_s1_b;
            FN_SUB:   w_alu_result = r_s1_a - r_s1_b;
            FN_MUL:   w_alu_result = r_s1_a * r_s1_b;
            FN_PASSA: w_alu_result = r_s1_a;
            FN_PASSB: w_alu_result = r_s1_b;
            FN_AND:   w_alu_result = r_s1_a & r_s1_b;
            FN_OR:    w_alu_result = r_s1_a | r_s1_b;
            FN_XOR:   w_alu_result = r_s1_a ^ r_s1_b;
            FN_NEGA:  w_alu_result = {DW{1'b0}} - r_s1_a;
            FN_NEGB:  w_alu_result = {DW{1'b0}} - r_s1_b;
            FN_SHR1:  w_alu_result = r_s1_a >> 1;
            FN_SHL1:  w_alu_result = r_s1_a << 1;
            FN_SHRB:  w_alu_result = r_s1_a >> r_s1_b[3:0];
            FN_SHLB:  w_alu_result = r_s1_a << r_s1_b[3:0];
            default: begin
                // Illegal codes retire with a zero result and the err flag.
                w_alu_result  = '0;
                w_alu_illegal = 1'b1;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Operand read with forwarding
    //
    // Two older instructions can still be in flight when a new one is read:
    //   - the one in the S1 registers (its result exists only as w_alu_result),
    //   - the one in the S2 registers (it writes the register bank at this same
    //     edge, so the bank still holds the stale value during the read).
    // The younger of the two wins. Illegal instructions and bubbles never write,
    // so they are never forwarding sources.
    // -------------------------------------------------------------------------
    assign w_fwd_exec_ok   = r_s1_valid && !w_alu_illegal;
    assign w_fwd_retire_ok = r_s2_valid && !r_s2_err;

    always_comb begin
        w_op_a = r_regbank[rs1];
        if (w_fwd_retire_ok && (r_s2_rd == rs1)) begin
            w_op_a = r_s2_result;
        end
        if (w_fwd_exec_ok && (r_s1_rd == rs1)) begin
            w_op_a = w_alu_result;
        end
    end

    always_comb begin
        w_op_b = r_regbank[rs2];
        if (w_fwd_retire_ok && (r_s2_rd == rs2)) begin
            w_op_b = r_s2_result;
        end
        if (w_fwd_exec_ok && (r_s1_rd == rs2)) begin
            w_op_b = w_alu_result;
        end
    end

    // -------------------------------------------------------------------------
    // S1: operand/control latch
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_rd     <= '0;
            r_s1_func   <= '0;
            r_s1_addr   <= '0;
            r_s1_wb_mem <= 1'b0;
        end else begin
            r_s1_valid  <= in_valid;
            r_s1_a      <= w_op_a;
            r_s1_b      <= w_op_b;
            r_s1_rd     <= rd;
            r_s1_func   <= func;
            r_s1_addr   <= addr;
            r_s1_wb_mem <= wb_mem;
        end
    end

    // -------------------------------------------------------------------------
    // S2: result latch
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid  <= 1'b0;
            r_s2_err    <= 1'b0;
            r_s2_result <= '0;
            r_s2_rd     <= '0;
            r_s2_addr   <= '0;
            r_s2_wb_mem <= 1'b0;
        end else begin
            r_s2_valid  <= r_s1_valid;
            r_s2_err    <= r_s1_valid && w_alu_illegal;
            r_s2_result <= w_alu_result;
            r_s2_rd     <= r_s1_rd;
            r_s2_addr   <= r_s1_addr;
            r_s2_wb_mem <= r_s1_wb_mem;
        end
    end

    // -------------------------------------------------------------------------
    // S3: writeback
    // -------------------------------------------------------------------------
    // A reset in the same cycle drops the retiring instruction entirely.
    assign w_retire_write = !rst && r_s2_valid && !r_s2_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Register k resets to the value k.
            for (int k = 0; k < RB_DEPTH; k++) begin
                r_regbank[k] <= DW'(k);
            end
        end else if (w_retire_write) begin
            r_regbank[r_s2_rd] <= r_s2_result;
        end
    end

    // Data memory keeps its contents through reset.
    always_ff @(posedge clk) begin
        if (w_retire_write && r_s2_wb_mem) begin
            r_mem[r_s2_addr] <= r_s2_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_zout       <= '0;
            r_zout_valid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_zout       <= r_s2_valid ? r_s2_result : '0;
            r_zout_valid <= r_s2_valid;
            r_err        <= r_s2_valid && r_s2_err;
        end
    end

    assign zout       = r_zout;
    assign zout_valid = r_zout_valid;
    assign err        = r_err;
    assign mem_rdata  = r_mem[mem_raddr];

endmodule
